f2i: RTL
========

F2I -- requirements
Module: f2i

Interface
REQ-001 SHALL have parameter MAN_WIDTH, default 7, bfloat16 mantissa width; only the default is supported.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, bfloat16 exponent width; only the default is supported.
REQ-003 SHALL have parameter BIAS, default 127, exponent bias.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-006 SHALL have port valid_i  input  1  operands valid; sampled only while ready_o=1.
REQ-007 SHALL have port sgn_i  input  1  bfloat16 sign.
REQ-008 SHALL have port exp_i  input  EXP_WIDTH  bfloat16 biased exponent.
REQ-009 SHALL have port mantissa_i  input  MAN_WIDTH  bfloat16 fraction, implicit leading 1.
REQ-010 SHALL have port ready_o  output  1  high only in IDLE.
REQ-011 SHALL have port parte_intera  output  8  two's-complement integer part of the Q8.7 result.
REQ-012 SHALL have port parte_frazionaria  output  7  fractional part of the Q8.7 result.
REQ-013 SHALL have port overflow_o  output  1  result saturated; valid with valid_o.
REQ-014 SHALL have port valid_o  output  1  one-cycle result strobe.

Function
REQ-015 SHALL interpret {parte_intera,parte_frazionaria} as a 15-bit two's-complement value R, where value = R/128.
REQ-016 SHALL form magnitude M = {1,mantissa_i} shifted by d = exp_i-BIAS (left if d>0, right if d<0), truncated toward zero.
REQ-017 SHALL implement the FSM IDLE -> SHIFT -> NEGATE -> DONE -> IDLE, with IDLE -> NEGATE taken directly when the shift count n=0.
REQ-018 SHALL, in IDLE when valid_i=1, register the operands, classify the input, load M={1,m} and set n=|d|.
REQ-019 SHALL, in SHIFT, move M one bit per cycle and decrement n, leaving SHIFT when n reaches 0.
REQ-020 SHALL, in NEGATE, apply saturation and then two's-complement negation if sgn=1, and register the outputs.
REQ-021 SHALL, in DONE, drive valid_o=1 for exactly one cycle and then return to IDLE.
REQ-022 SHALL assert valid_o n+2 cycles after the sampling edge; outputs hold until the next NEGATE.
REQ-023 SHALL treat exp_i=0 (zero or denormal) as a zero result with n=0.
REQ-024 SHALL treat exp_i<=119 as a zero result with n=0 (underflow).
REQ-025 SHALL treat d>=7 as a saturating result with n=0, except sgn=1, exp=134, m=0, which gives exact -128 (0x80,0x00) with overflow_o=0.
REQ-026 SHALL make saturation produce R=0x3FFF if sgn=0 and R=0x4000 if sgn=1, with overflow_o=1.
REQ-027 SHALL treat exp_i=255 (Inf or NaN) as saturation per sign, with overflow_o=1.
REQ-028 SHALL bound n at 8 right shifts or 6 left shifts, giving a maximum latency of 10 cycles.
REQ-029 SHALL ignore valid_i while ready_o=0; inputs presented then are dropped and never queued.
REQ-030 SHALL sample a new operand in the IDLE cycle that follows DONE.

Reset
REQ-031 SHALL, while rst=0, force state=IDLE, ready_o=1, valid_o=0, overflow_o=0, parte_intera=0x00, parte_frazionaria=0x00, and clear all internal registers.
REQ-032 SHALL, on reset during SHIFT, NEGATE or DONE, abort the conversion with no valid_o pulse.
REQ-033 SHALL allow the first valid_i to be accepted on the first rising edge after rst returns to 1.

Configuration
REQ-034 SHALL, when the macro F2I_ROUND_EN is defined, round right shifts to nearest-even using guard and sticky bits.
REQ-035 SHALL, when F2I_ROUND_EN is defined, take exp_i=119 through the 8-shift path (underflow becomes exp_i<=118).
REQ-036 SHALL, when F2I_ROUND_EN is defined, re-check saturation after rounding in NEGATE; latency is unchanged.
REQ-037 SHALL, when F2I_ROUND_EN is undefined, truncate toward zero per REQ-016, with no guard or sticky logic.

Verification
REQ-038 SHALL cover: sgn=0, exp=0x7F, m=0x40 (1.5) -> parte_intera=0x01, parte_frazionaria=0x40, overflow_o=0, valid_o 2 cycles after sampling.
REQ-039 SHALL cover: sgn=1, exp=0x80, m=0x10 (-2.25) -> parte_intera=0xFD, parte_frazionaria=0x60, valid_o 3 cycles after sampling.
REQ-040 SHALL cover: sgn=1, exp=0x86, m=0x00 -> 0x80/0x00 with overflow_o=0; and sgn=0, exp=0x86, m=0x48 (200.0) -> 0x7F/0x7F with overflow_o=1.
REQ-041 SHALL cover: exp=0x78, m=0x7F -> 0x00/0x01 after 9 cycles without the macro, and 0x00/0x02 with F2I_ROUND_EN.
REQ-042 SHALL cover: exp=0x70 -> 0x00/0x00 after 2 cycles; and exp=0xFF with sgn=1 -> 0x80/0x00 with overflow_o=1.
REQ-043 SHALL cover: rst pulsed low during SHIFT -> no valid_o, outputs 0, and the next operand converts correctly.

Source files
------------

// File: rtl/f2i.sv
// bfloat16 to Q8.7 fixed-point converter: iterative one-bit-per-cycle shifter with saturation.
// Optional round-to-nearest-even on right shifts when F2I_ROUND_EN is defined.
module f2i #(
   parameter int MAN_WIDTH = 7,
   parameter int EXP_WIDTH = 8,
   parameter int BIAS      = 127
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic                 sgn_i,
   input  logic [EXP_WIDTH-1:0] exp_i,
   input  logic [MAN_WIDTH-1:0] mantissa_i,
   output logic                 ready_o,
   output logic [7:0]           parte_intera,
   output logic [6:0]           parte_frazionaria,
   output logic                 overflow_o,
   output logic                 valid_o
);

   // state    | meaning
   // S_IDLE   | waiting for an operand, ready_o high
   // S_SHIFT  | moving the magnitude one bit per cycle
   // S_NEGATE | saturate, apply sign, register result
   // S_DONE   | one-cycle valid_o strobe
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_NEGATE, S_DONE} state_t;

   localparam logic [EXP_WIDTH-1:0] EXP_BIAS = EXP_WIDTH'(BIAS);
   localparam logic [EXP_WIDTH-1:0] EXP_SAT  = EXP_WIDTH'(BIAS + 7);
`ifdef F2I_ROUND_EN
   localparam logic [EXP_WIDTH-1:0] EXP_UFL  = EXP_WIDTH'(BIAS - 9);
`else
   localparam logic [EXP_WIDTH-1:0] EXP_UFL  = EXP_WIDTH'(BIAS - 8);
`endif
   localparam logic [14:0] R_POS_SAT = 15'h3FFF;
   localparam logic [14:0] R_NEG_SAT = 15'h4000;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_sgn;
   logic          r_left;
   logic          r_sat;
   logic [3:0]    r_n;
   logic [14:0]   r_mag;
   logic [14:0]   r_res;
   logic          r_ovf;

   logic [MAN_WIDTH:0] w_mant;
   logic          w_zero;
   logic          w_big;
   logic          w_exact;
   logic          w_left;
   logic [3:0]    w_n;
   logic [14:0]   w_mag_ld;
   logic [14:0]   w_mag_fin;
   logic          w_ovf;
   logic [14:0]   w_res;

   // exp_i=255 (Inf/NaN) falls inside w_big and saturates by sign.
   assign w_mant  = {1'b1, mantissa_i};
   assign w_zero  = (exp_i <= EXP_UFL);
   assign w_big   = (exp_i >= EXP_SAT);
   assign w_exact = sgn_i && (exp_i == EXP_SAT) && (mantissa_i == '0);
   assign w_left  = (exp_i > EXP_BIAS);

   always_comb begin
      w_n      = 4'd0;
      w_mag_ld = 15'(w_mant);
      if (w_zero) begin
         w_mag_ld = 15'd0;
      end else if (w_exact) begin
         w_mag_ld = R_NEG_SAT;
      end else if (w_big) begin
         w_mag_ld = 15'd0;
      end else if (w_left) begin
         w_n = 4'(exp_i - EXP_BIAS);
      end else begin
         w_n = 4'(EXP_BIAS - exp_i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (valid_i) w_state_nxt = (w_n == 4'd0) ? S_NEGATE : S_SHIFT;
         S_SHIFT:  if (r_n == 4'd1) w_state_nxt = S_NEGATE;
         S_NEGATE: w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

`ifdef F2I_ROUND_EN
   logic r_guard;
   logic r_sticky;
   logic w_inc;

   // guard/sticky only ever become non-zero on the right-shift path.
   assign w_inc     = r_guard && (r_sticky || r_mag[0]);
   assign w_mag_fin = r_mag + 15'(w_inc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_guard  <= 1'b0;
         r_sticky <= 1'b0;
      end else if (r_state == S_IDLE && valid_i) begin
         r_guard  <= 1'b0;
         r_sticky <= 1'b0;
      end else if (r_state == S_SHIFT && !r_left) begin
         r_guard  <= r_mag[0];
         r_sticky <= r_sticky | r_guard;
      end
   end
`else
   assign w_mag_fin = r_mag;
`endif

   assign w_ovf = r_sat || (r_sgn ? (w_mag_fin > R_NEG_SAT) : (w_mag_fin > R_POS_SAT));

   always_comb begin
      w_res = w_mag_fin;
      if (w_ovf) begin
         w_res = r_sgn ? R_NEG_SAT : R_POS_SAT;
      end else if (r_sgn) begin
         w_res = ~w_mag_fin + 15'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_sgn   <= 1'b0;
         r_left  <= 1'b0;
         r_sat   <= 1'b0;
         r_n     <= 4'd0;
         r_mag   <= 15'd0;
         r_res   <= 15'd0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: if (valid_i) begin
               r_sgn  <= sgn_i;
               r_left <= w_left;
               r_sat  <= w_big && !w_exact && !w_zero;
               r_n    <= w_n;
               r_mag  <= w_mag_ld;
            end
            S_SHIFT: begin
               r_mag <= r_left ? {r_mag[13:0], 1'b0} : {1'b0, r_mag[14:1]};
               r_n   <= r_n - 4'd1;
            end
            S_NEGATE: begin
               r_res <= w_res;
               r_ovf <= w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign ready_o           = (r_state == S_IDLE);
   assign valid_o           = (r_state == S_DONE);
   assign parte_intera      = r_res[14:7];
   assign parte_frazionaria = r_res[6:0];
   assign overflow_o        = r_ovf;

endmodule
